// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, operand field extraction and the S1 compare payload
package fp_pkg;
  localparam int EXP_W_D = 8;
  localparam int FRAC_W_D = 18;
  localparam int GUARD_W_D = 3;
  localparam int OP_MAX_W = 64;
  localparam int DIFF_MAX_W = 33;
  typedef struct packed {
    logic swap;
    logic [DIFF_MAX_W-1:0] diff;
  } s1_t;
  function automatic logic op_sign(input logic [OP_MAX_W-1:0] op, input int exp_w, input int frac_w);
    return op[exp_w+frac_w];
  endfunction
  function automatic logic [31:0] op_exp(input logic [OP_MAX_W-1:0] op, input int exp_w, input int frac_w);
    return 32'((op >> frac_w) & ((64'd1 << exp_w) - 64'd1));
  endfunction
  function automatic logic [OP_MAX_W-1:0] op_frac(input logic [OP_MAX_W-1:0] op, input int frac_w);
    return op & ((64'd1 << frac_w) - 64'd1);
  endfunction
endpackage

// File: rtl/fp_shift_right_sticky.sv
// fp_shift_right_sticky: right shift with sticky ORed into the LSB, saturating
//   data  : value to shift       shift : shift amount
//   res   : shifted value, LSB carries OR of all bits shifted out
module fp_shift_right_sticky #(
  parameter int DATA_W = 21,
  parameter int SH_W = 33
) (
  input  logic [DATA_W-1:0] data,
  input  logic [SH_W-1:0]   shift,
  output logic [DATA_W-1:0] res
);
  logic sat, sticky;
  logic [DATA_W-1:0] lost_mask;
  always_comb begin
    sat = 64'(shift) >= 64'(DATA_W);
    lost_mask = ~({DATA_W{1'b1}} << shift);
    sticky = |(data & lost_mask);
    res = sat ? DATA_W'(|data) : (data >> shift) | DATA_W'(sticky);
  end
endmodule

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage valid/ready exponent aligner (S1 compare, S2 shift)
//   in_valid/in_ready, in_1/in_2    : operand pair {sign, exp, frac}
//   out_valid/out_ready, out_1/out_2 : aligned pair {sign, exp, frac, guard}
//   out_swapped                      : operand 1 was the one shifted
module fp_align_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_D,
  parameter int FRAC_W = FRAC_W_D,
  parameter int GUARD_W = GUARD_W_D,
  localparam int OP_W = 1 + EXP_W + FRAC_W,
  localparam int RES_W = OP_W + GUARD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_1,
  input  logic [OP_W-1:0]  in_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_1,
  output logic [RES_W-1:0] out_2,
  output logic             out_swapped
);
  localparam int EXT_W = FRAC_W + GUARD_W;
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic [OP_W-1:0] s1_op_1, s1_op_2;
  s1_t s1_q, s1_d;
  logic signed [EXP_W-1:0] e1, e2;
  logic [EXP_W:0] x1, x2, diff;
  logic [EXP_W-1:0] q_e1, q_e2, exp_max;
  logic [FRAC_W-1:0] q_f1, q_f2;
  logic [EXT_W-1:0] sh_in, sh_out, big_ext;
  logic [RES_W-1:0] res_1, res_2;
  assign s2_adv = !s2_valid | out_ready;
  assign s1_adv = !s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_valid;
  always_comb begin
    e1 = EXP_W'(op_exp(OP_MAX_W'(in_1), EXP_W, FRAC_W));
    e2 = EXP_W'(op_exp(OP_MAX_W'(in_2), EXP_W, FRAC_W));
    x1 = {e1[EXP_W-1], e1};
    x2 = {e2[EXP_W-1], e2};
    s1_d.swap = e2 > e1;
    // One extra bit keeps the difference of extreme exponents from wrapping
    diff = s1_d.swap ? x2 - x1 : x1 - x2;
    s1_d.diff = DIFF_MAX_W'(diff);
  end
  always_comb begin
    q_e1 = EXP_W'(op_exp(OP_MAX_W'(s1_op_1), EXP_W, FRAC_W));
    q_e2 = EXP_W'(op_exp(OP_MAX_W'(s1_op_2), EXP_W, FRAC_W));
    q_f1 = FRAC_W'(op_frac(OP_MAX_W'(s1_op_1), FRAC_W));
    q_f2 = FRAC_W'(op_frac(OP_MAX_W'(s1_op_2), FRAC_W));
    exp_max = s1_q.swap ? q_e2 : q_e1;
    sh_in = {s1_q.swap ? q_f1 : q_f2, {GUARD_W{1'b0}}};
    big_ext = {s1_q.swap ? q_f2 : q_f1, {GUARD_W{1'b0}}};
    res_1 = {op_sign(OP_MAX_W'(s1_op_1), EXP_W, FRAC_W), exp_max, s1_q.swap ? sh_out : big_ext};
    res_2 = {op_sign(OP_MAX_W'(s1_op_2), EXP_W, FRAC_W), exp_max, s1_q.swap ? big_ext : sh_out};
  end
  fp_shift_right_sticky #(.DATA_W(EXT_W), .SH_W(DIFF_MAX_W)) u_shift (
    .data(sh_in),
    .shift(s1_q.diff),
    .res(sh_out)
  );
  // Payloads load only with a valid entry so out_* stays at its last real value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op_1 <= '0;
      s1_op_2 <= '0;
      s1_q <= '0;
      s2_valid <= 1'b0;
      out_1 <= '0;
      out_2 <= '0;
      out_swapped <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s1_adv && in_valid) begin
        s1_op_1 <= in_1;
        s1_op_2 <= in_2;
        s1_q <= s1_d;
      end
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        out_1 <= res_1;
        out_2 <= res_2;
        out_swapped <= s1_q.swap;
      end
    end
  end
endmodule

// File: tb/tb_fp_align_pipe.sv
// tb_fp_align_pipe: directed vectors plus backpressure and reset sequences
module tb_fp_align_pipe;
  localparam int OP_W = 27;
  localparam int RES_W = 30;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_swapped;
  logic [OP_W-1:0] in_1 = '0, in_2 = '0;
  logic [RES_W-1:0] out_1, out_2;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    logic [OP_W-1:0] a, b;
    logic [RES_W-1:0] ra, rb;
    logic sw;
  } vec_t;
  vec_t v[10];
  fp_align_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_1(in_1), .in_2(in_2), .out_valid(out_valid), .out_ready(out_ready),
    .out_1(out_1), .out_2(out_2), .out_swapped(out_swapped)
  );
  always #5 clk = ~clk;
  function automatic logic [OP_W-1:0] mk_op(input logic s, input logic [7:0] e, input logic [17:0] f);
    return {s, e, f};
  endfunction
  function automatic logic [RES_W-1:0] mk_res(input logic s, input logic [7:0] e, input logic [20:0] f);
    return {s, e, f};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_out(input string nm, input int k);
    chk({nm, "_out_1"}, 64'(out_1), 64'(v[k].ra));
    chk({nm, "_out_2"}, 64'(out_2), 64'(v[k].rb));
    chk({nm, "_swapped"}, 64'(out_swapped), 64'(v[k].sw));
  endtask
  initial begin
    v[0] = '{mk_op(0, 8'h05, 18'h20000), mk_op(0, 8'h03, 18'h20001), mk_res(0, 8'h05, 21'h100000), mk_res(0, 8'h05, 21'h40002), 1'b0};
    v[1] = '{mk_op(0, 8'h04, 18'h00001), mk_op(1, 8'h00, 18'h00009), mk_res(0, 8'h04, 21'h8), mk_res(1, 8'h04, 21'h5), 1'b0};
    v[2] = '{mk_op(0, 8'hFD, 18'h3FFFF), mk_op(0, 8'h02, 18'h00001), mk_res(0, 8'h02, 21'hFFFF), mk_res(0, 8'h02, 21'h8), 1'b1};
    v[3] = '{mk_op(0, 8'h7F, 18'h00010), mk_op(0, 8'h80, 18'h00001), mk_res(0, 8'h7F, 21'h80), mk_res(0, 8'h7F, 21'h1), 1'b0};
    v[4] = '{mk_op(0, 8'h7F, 18'h00010), mk_op(0, 8'h80, 18'h00000), mk_res(0, 8'h7F, 21'h80), mk_res(0, 8'h7F, 21'h0), 1'b0};
    v[5] = '{mk_op(1, 8'h07, 18'h00003), mk_op(0, 8'h07, 18'h00005), mk_res(1, 8'h07, 21'h18), mk_res(0, 8'h07, 21'h28), 1'b0};
    v[6] = '{mk_op(0, 8'd19, 18'h00001), mk_op(0, 8'h00, 18'h20000), mk_res(0, 8'd19, 21'h8), mk_res(0, 8'd19, 21'h2), 1'b0};
    v[7] = '{mk_op(0, 8'd21, 18'h00001), mk_op(0, 8'h00, 18'h20000), mk_res(0, 8'd21, 21'h8), mk_res(0, 8'd21, 21'h1), 1'b0};
    v[8] = '{mk_op(0, 8'hF0, 18'h00001), mk_op(1, 8'hF2, 18'h00002), mk_res(0, 8'hF2, 21'h2), mk_res(1, 8'hF2, 21'h10), 1'b1};
    v[9] = '{mk_op(0, 8'h80, 18'h3FFFF), mk_op(0, 8'h7F, 18'h00002), mk_res(0, 8'h7F, 21'h1), mk_res(0, 8'h7F, 21'h10), 1'b1};
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_1", 64'(out_1), 64'(0));
    chk("rst_out_2", 64'(out_2), 64'(0));
    chk("rst_swapped", 64'(out_swapped), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_1 = v[i].a;
      in_2 = v[i].b;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1 chk("vec_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      in_valid = 1'b0;
      chk("vec_early_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      chk("vec_out_valid", 64'(out_valid), 64'(1));
      chk_out($sformatf("vec%0d", i), i);
    end
    begin
      int sent = 0;
      int got = 0;
      for (int c = 0; c < 30 && got < 4; c++) begin
        @(negedge clk);
        in_valid = sent < 4;
        in_1 = v[sent < 4 ? sent : 0].a;
        in_2 = v[sent < 4 ? sent : 0].b;
        out_ready = c >= 5;
        #1;
        if (c >= 2 && c <= 4) chk("bp_in_ready", 64'(in_ready), 64'(0));
        if (out_valid) chk_out($sformatf("bp%0d", got), got);
        if (in_valid && in_ready) sent++;
        if (out_valid && out_ready) got++;
      end
      in_valid = 1'b0;
      chk("bp_received", 64'(got), 64'(4));
    end
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_1 = v[i].a;
      in_2 = v[i].b;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_out_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_out_1", 64'(out_1), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 64'(out_valid), 64'(0));
    end
    @(negedge clk);
    in_1 = v[2].a;
    in_2 = v[2].b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'(1));
    chk_out("post_rst", 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
